// File: rtl/systolic_writeback_if.sv
// Memory write port between the systolic drain engine and the shared memory.
//   mem_wr_en : write request (master -> slave)
//   addr_wr   : word write address (master -> slave)
//   data_wr   : write data (master -> slave)
//   wr_ready  : slave accepts the write this cycle (slave -> master)
interface systolic_writeback_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  mem_wr_en;
  logic [ADDR_WIDTH-1:0] addr_wr;
  logic [DATA_WIDTH-1:0] data_wr;
  logic                  wr_ready;

  modport master (output mem_wr_en, output addr_wr, output data_wr, input wr_ready);
  modport slave  (input mem_wr_en, input addr_wr, input data_wr, output wr_ready);
endinterface

// File: rtl/systolic_writeback.sv
// Drain engine for the systolic array result vector. On a rising edge of
// y_valid it snapshots Y and streams the M*K elements, in ascending order,
// as single-word writes starting at OUTPUT_BASE, honouring wr_ready.
// Ports:
//   clk, rst_systolic : clock (rising edge) and async active-low reset
//   Y, y_valid        : flat array result and its done level
//   wr                : memory write port (mem_wr_en/addr_wr/data_wr, wr_ready)
//   busy              : capture edge through the wb_done cycle
//   wb_done           : one-cycle pulse after the last accepted write
//   overrun           : sticky, y_valid rose while a drain was in progress
// Optional build macro: SYSTOLIC_WB_RELU_EN clamps negative elements to zero
// on the write data (snapshot keeps raw values).
module systolic_writeback #(
  parameter int unsigned           M           = 9,
  parameter int unsigned           K           = 5,
  parameter int unsigned           DATA_WIDTH  = 32,
  parameter int unsigned           ADDR_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] OUTPUT_BASE = ADDR_WIDTH'(32'h00003000)
) (
  input  logic                         clk,
  input  logic                         rst_systolic,
  input  logic [DATA_WIDTH*M*K-1:0]    Y,
  input  logic                         y_valid,
  systolic_writeback_if.master         wr,
  output logic                         busy,
  output logic                         wb_done,
  output logic                         overrun
);
  localparam int unsigned N     = M * K;
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_DONE} state_t;

  state_t                    state, state_nxt;
  logic [IDX_W-1:0]          idx, idx_nxt;
  logic [DATA_WIDTH*N-1:0]   snap;
  logic                      y_prev;
  logic                      rise, load, accept;
  logic [DATA_WIDTH-1:0]     elem_nxt;

  logic                      wr_en_q, wr_en_nxt;
  logic [ADDR_WIDTH-1:0]     addr_q, addr_nxt;
  logic [DATA_WIDTH-1:0]     data_q, data_nxt;
  logic                      busy_nxt, done_nxt, ovr_nxt;

  // Output-side data filter applied after the snapshot mux
  function automatic logic [DATA_WIDTH-1:0] wb_filter(input logic [DATA_WIDTH-1:0] e);
`ifdef SYSTOLIC_WB_RELU_EN
    return e[DATA_WIDTH-1] ? '0 : e;
`else
    return e;
`endif
  endfunction

  assign rise   = y_valid & ~y_prev;
  assign accept = (state == S_WRITE) & wr_en_q & wr.wr_ready;

  // State register
  always_ff @(posedge clk or negedge rst_systolic) begin
    if (!rst_systolic) state <= S_IDLE;
    else               state <= state_nxt;
  end

  // Next state and next registered outputs
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    load      = 1'b0;
    case (state)
      S_IDLE: begin
        if (rise) begin
          state_nxt = S_WRITE;
          idx_nxt   = '0;
          load      = 1'b1;
        end
      end
      S_WRITE: begin
        if (accept) begin
          if (idx == LAST_IDX) state_nxt = S_DONE;
          else                 idx_nxt   = idx + IDX_W'(1);
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase

    // Element 0 comes straight from Y on capture since snap is not yet loaded
    elem_nxt  = load ? Y[DATA_WIDTH-1:0] : snap[32'(idx_nxt)*DATA_WIDTH +: DATA_WIDTH];
    data_nxt  = wb_filter(elem_nxt);
    addr_nxt  = OUTPUT_BASE + ADDR_WIDTH'(idx_nxt);
    wr_en_nxt = (state_nxt == S_WRITE);
    done_nxt  = (state_nxt == S_DONE);
    busy_nxt  = (state_nxt != S_IDLE);
    ovr_nxt   = overrun | (rise & (state != S_IDLE));
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_systolic) begin
    if (!rst_systolic) begin
      idx     <= '0;
      snap    <= '0;
      y_prev  <= 1'b0;
      wr_en_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      busy    <= 1'b0;
      wb_done <= 1'b0;
      overrun <= 1'b0;
    end else begin
      idx     <= idx_nxt;
      y_prev  <= y_valid;
      if (load) snap <= Y;
      wr_en_q <= wr_en_nxt;
      addr_q  <= addr_nxt;
      data_q  <= data_nxt;
      busy    <= busy_nxt;
      wb_done <= done_nxt;
      overrun <= ovr_nxt;
    end
  end

  assign wr.mem_wr_en = wr_en_q;
  assign wr.addr_wr   = addr_q;
  assign wr.data_wr   = data_q;
endmodule

// File: tb/tb_systolic_writeback.sv
// Directed bench for systolic_writeback with a write scoreboard.
module tb_systolic_writeback;
  localparam int unsigned M  = 9;
  localparam int unsigned K  = 5;
  localparam int unsigned N  = M * K;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  logic              clk = 1'b0;
  logic              rst_systolic;
  logic [DW*N-1:0]   y_bus;
  logic              y_valid;
  logic              busy, wb_done, overrun;
  int                total = 0;
  int                bad   = 0;
  wr_t               sb[$];

  systolic_writeback_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) wb_if ();

  systolic_writeback #(
    .M(M), .K(K), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .OUTPUT_BASE(32'h00003000)
  ) dut (
    .clk(clk), .rst_systolic(rst_systolic), .Y(y_bus), .y_valid(y_valid),
    .wr(wb_if), .busy(busy), .wb_done(wb_done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] model_data(input logic [DW-1:0] v);
`ifdef SYSTOLIC_WB_RELU_EN
    return v[DW-1] ? '0 : v;
`else
    return v;
`endif
  endfunction

  // Load Y (mode 0: e+1, mode 1: -e) and push the expected writes
  task automatic load_y(input int mode);
    logic [DW-1:0] v;
    for (int e = 0; e < int'(N); e++) begin
      v = (mode == 0) ? DW'(e + 1) : DW'(-e);
      y_bus[e*DW +: DW] = v;
      sb.push_back('{a: AW'(32'h3000 + e), d: model_data(v)});
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Raise y_valid, then follow the drain cycle by cycle.
  // mode 0 ready=1; 1 ready toggles; 2 Y corrupted after capture;
  // 3 re-rise of y_valid at index 10; 4 reset at index 20
  task automatic drain(input int mode, input int exp_cyc);
    int            cyc = 0;
    int            writes = 0;
    int            phase = 0;
    bit            prev_stall = 0;
    logic [AW-1:0] pa;
    logic [DW-1:0] pd;
    wr_t           w;
    y_valid = 1'b1;
    forever begin
      tick();
      cyc++;
      if (cyc > 400) begin
        chk("drain_timeout", 64'(cyc), 64'(exp_cyc));
        return;
      end
      if (wb_done) begin
        chk("done_cycle", 64'(cyc), 64'(exp_cyc));
        chk("done_writes", 64'(writes), 64'(N));
        chk("done_sb_empty", 64'(sb.size()), 64'(0));
        chk("done_busy", 64'(busy), 64'(1));
        chk("done_wr_en", 64'(wb_if.mem_wr_en), 64'(0));
        wb_if.wr_ready = 1'b0;
        tick();
        chk("post_busy", 64'(busy), 64'(0));
        chk("post_done", 64'(wb_done), 64'(0));
        return;
      end
      if (cyc == 1) begin
        chk("first_req", 64'(wb_if.mem_wr_en), 64'(1));
        chk("first_busy", 64'(busy), 64'(1));
        if (mode == 2) y_bus = '1;
      end
      if (mode == 3) begin
        if (phase == 0 && writes == 10) begin y_valid = 1'b0; phase = 1; end
        else if (phase == 1) begin y_valid = 1'b1; phase = 2; end
      end
      if (mode == 4 && writes == 20) begin
        rst_systolic = 1'b0;
        #1;
        chk("rst_wr_en", 64'(wb_if.mem_wr_en), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(wb_done), 64'(0));
        sb.delete();
        y_valid = 1'b0;
        wb_if.wr_ready = 1'b0;
        return;
      end
      if (prev_stall) begin
        chk("stall_addr", 64'(wb_if.addr_wr), 64'(pa));
        chk("stall_data", 64'(wb_if.data_wr), 64'(pd));
      end
      wb_if.wr_ready = (mode == 1) ? ((cyc % 2) == 1) : 1'b1;
      pa = wb_if.addr_wr;
      pd = wb_if.data_wr;
      prev_stall = wb_if.mem_wr_en && !wb_if.wr_ready;
      if (wb_if.mem_wr_en && wb_if.wr_ready) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", 64'(writes), 64'(N));
        end else begin
          w = sb.pop_front();
          chk("wr_addr", 64'(wb_if.addr_wr), 64'(w.a));
          chk("wr_data", 64'(wb_if.data_wr), 64'(w.d));
        end
        writes++;
      end
    end
  endtask

  // Hold current inputs for n cycles; count requests and done pulses
  task automatic idle_watch(input int n, input string tag);
    int reqs = 0;
    wb_if.wr_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      tick();
      if (wb_if.mem_wr_en || wb_done) reqs++;
    end
    wb_if.wr_ready = 1'b0;
    chk(tag, 64'(reqs), 64'(0));
  endtask

  initial begin
    rst_systolic   = 1'b0;
    y_valid        = 1'b0;
    y_bus          = '0;
    wb_if.wr_ready = 1'b0;
    repeat (3) tick();
    chk("rst_state_wr_en", 64'(wb_if.mem_wr_en), 64'(0));
    chk("rst_state_addr", 64'(wb_if.addr_wr), 64'(0));
    chk("rst_state_data", 64'(wb_if.data_wr), 64'(0));
    chk("rst_state_busy", 64'(busy), 64'(0));
    chk("rst_state_done", 64'(wb_done), 64'(0));
    chk("rst_state_ovr", 64'(overrun), 64'(0));
    rst_systolic = 1'b1;
    repeat (2) tick();

    // Full-rate drain
    load_y(0);
    drain(0, int'(N) + 1);
    chk("ovr_after_clean", 64'(overrun), 64'(0));
    y_valid = 1'b0;
    repeat (2) tick();

    // Alternating backpressure
    load_y(0);
    drain(1, 2 * int'(N));
    y_valid = 1'b0;
    repeat (2) tick();

    // Y corrupted right after capture
    load_y(0);
    drain(2, int'(N) + 1);
    y_valid = 1'b0;
    repeat (2) tick();

    // Retrigger mid-drain sets overrun only
    load_y(0);
    drain(3, int'(N) + 1);
    chk("ovr_sticky", 64'(overrun), 64'(1));
    idle_watch(20, "no_redrain_after_ovr");
    chk("ovr_still_set", 64'(overrun), 64'(1));
    y_valid = 1'b0;
    repeat (2) tick();

    // Reset mid-drain, then a clean full drain with y_valid held high
    load_y(0);
    drain(4, 0);
    repeat (2) tick();
    chk("rst_ovr_clr", 64'(overrun), 64'(0));
    rst_systolic = 1'b1;
    idle_watch(5, "no_done_after_abort");
    load_y(0);
    drain(0, int'(N) + 1);
    idle_watch(200, "held_valid_single_drain");
    chk("held_valid_ovr", 64'(overrun), 64'(0));
    y_valid = 1'b0;
    repeat (2) tick();

    // Negative elements
    load_y(1);
    drain(0, int'(N) + 1);
    y_valid = 1'b0;
    repeat (2) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/systolic_writeback.md
# systolic_writeback

Drain engine on the output side of the systolic array: it snapshots the flat result vector `Y` when the array signals completion and serialises it into the shared memory as one word write per accepted cycle at `OUTPUT_BASE`. It replaces direct multi-word result stores with a single-port, backpressure-aware write stream. It pairs with the X/W feeder that loads operand rows into the array. It runs on the same reset domain as the systolic array.

## Interface
- `M`, 9, result rows (output pixels)
- `K`, 5, result columns (filters)
- `DATA_WIDTH`, 32, word width
- `ADDR_WIDTH`, 32, memory address width
- `OUTPUT_BASE`, 32'h00003000, word address of element 0

- `clk`  in  1  clock; all logic on rising edge
- `rst_systolic`  in  1  reset, asynchronous, active-low
- `Y`  in  DATA_WIDTH*M*K  array result; element e=i*K+j at bits [e*DATA_WIDTH +: DATA_WIDTH]
- `y_valid`  in  1  array done level; only its rising edge triggers a drain
- `wr_ready`  in  1  memory port accepts a write this cycle
- `mem_wr_en`  out  1  write request
- `addr_wr`  out  ADDR_WIDTH  write address
- `data_wr`  out  DATA_WIDTH  write data
- `busy`  out  1  high from capture edge until wb_done cycle inclusive
- `wb_done`  out  1  one-cycle pulse after the last write is accepted
- `overrun`  out  1  sticky; rising edge of y_valid seen while busy

## Operation
- States: IDLE, WRITE, DONE. Reset forces IDLE; all outputs 0, index 0, snapshot register 0, edge-detect register 0.
- Edge detect: `y_prev` registers `y_valid` every cycle; rise = y_valid & ~y_prev.
- IDLE: on rise, latch full `Y` into snapshot, index←0, →WRITE. No rise: stay.
- WRITE: `mem_wr_en`=1, `addr_wr`=OUTPUT_BASE+index (ADDR_WIDTH arithmetic, wraps modulo 2^ADDR_WIDTH), `data_wr`=snapshot element [index]. A write is accepted on a cycle with mem_wr_en & wr_ready; index increments by 1. Accept at index M*K-1 →DONE.
- DONE: `wb_done`=1, `mem_wr_en`=0, →IDLE next cycle.
- Element order strictly ascending e=0..M*K-1; no gaps, no duplicates.
- Snapshot decouples from `Y`: changes to `Y` after capture do not affect written data.
- Rise while in WRITE or DONE: ignored for draining, sets `overrun`=1 (cleared only by reset). Rise in the same cycle DONE returns to IDLE is also overrun; the next drain needs a fresh rise.
- `y_valid` held high continuously triggers exactly one drain.
- Reset mid-drain: immediate abort; mem_wr_en drops asynchronously, no wb_done, remaining words not written.

## Timing
- Capture edge t (rise sampled): first request visible in cycle t+1.
- wr_ready held high: one word per cycle; last accept at edge t+M*K; wb_done high in cycle t+M*K+1; busy falls after that cycle. Total M*K+1 cycles busy.
- wr_ready low: mem_wr_en, addr_wr, data_wr held stable until accepted; each stall cycle adds one cycle of latency.
- Outputs registered; no combinational path from wr_ready or y_valid to any output.

## Configuration
- `SYSTOLIC_WB_RELU_EN` defined: data_wr = 0 when the element's MSB (signed two's complement) is 1, else element unchanged. Applied at output mux; snapshot holds raw values.
- Undefined: data_wr = raw element. Address, ordering and timing identical in both builds.

## Test plan
- M=9,K=5, Y element e = e+1, wr_ready=1, single y_valid rise -> 45 writes, addr 0x3000..0x302C, data 1..45, wb_done pulse 46 cycles after capture edge, overrun=0.
- Same, wr_ready toggling 1,0,1,0 -> addr/data stable across stalls, each word written exactly once, wb_done after 90 cycles.
- Y changed to all 0xFFFFFFFF one cycle after capture -> memory still receives 1..45.
- Second y_valid rise at write index 10 -> drain continues unaffected, overrun=1 persists after wb_done; y_valid held high for 200 cycles -> exactly one drain.
- rst_systolic low at index 20 -> mem_wr_en=0 immediately, busy=0, no wb_done; subsequent rise -> full 45-word drain from 0x3000.
- Element e = -e (e.g. 0xFFFFFFFE at e=2): with SYSTOLIC_WB_RELU_EN data_wr=0 for e≥1; without, raw values written.
